// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared pointer-width constants and Gray/binary conversion
//               helpers for the dual-clock FIFO pointer blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int ASIZE_DEF = 4;
    localparam int PTR_W     = ASIZE_DEF + 1;

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin
// Description : Combinational Gray-to-binary converter (XOR prefix from MSB).
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule
`default_nettype wire

// File: rtl/rptr_empty_lvl.sv
`default_nettype none
// ============================================================================
// Module      : rptr_empty_lvl
// Description : Read-domain pointer, empty/almost-empty flags, fill level,
//               sticky underflow and single-cycle flush for the async FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module rptr_empty_lvl
    import fifo_pkg::*;
#(
    parameter int ASIZE    = ASIZE_DEF,
    parameter int AE_RESET = 2
) (
    input  logic             rd_clk,
    input  logic             rrst,
    input  logic             rd_en,
    input  logic             rflush,
    input  logic [ASIZE:0]   s_wptr,
    input  logic             ae_thresh_we,
    input  logic [ASIZE:0]   ae_thresh_in,
    input  logic             urun_clr,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rcount,
    output logic             runderflow
);

    localparam logic [ASIZE:0] c_AE_RESET = AE_RESET[ASIZE:0];

    logic [ASIZE:0] r_rbin;
    logic [ASIZE:0] r_rptr;
    logic [ASIZE:0] r_rcount;
    logic [ASIZE:0] r_thresh;
    logic           r_rempty;
    logic           r_ralmost_empty;
    logic           r_runderflow;

    logic [ASIZE:0] w_wbin;
    logic           w_pop;
    logic [ASIZE:0] w_bnext;
    logic [ASIZE:0] w_gnext;
    logic [ASIZE:0] w_cnext;

    gray2bin #(
        .WIDTH (ASIZE + 1)
    ) u_wptr_g2b (
        .i_gray (s_wptr),
        .o_bin  (w_wbin)
    );

    // Flush jumps straight to the synchronised write pointer; no pop that cycle.
    assign w_pop   = rd_en & ~r_rempty;
    assign w_bnext = rflush ? w_wbin : r_rbin + {{ASIZE{1'b0}}, w_pop};
    assign w_gnext = (w_bnext >> 1) ^ w_bnext;
    assign w_cnext = w_wbin - w_bnext;

    always_ff @(posedge rd_clk) begin
        if (rrst) begin
            r_rbin          <= '0;
            r_rptr          <= '0;
            r_rempty        <= 1'b1;
            r_ralmost_empty <= 1'b1;
            r_rcount        <= '0;
            r_runderflow    <= 1'b0;
            r_thresh        <= c_AE_RESET;
        end else begin
            r_rbin          <= w_bnext;
            r_rptr          <= w_gnext;
            r_rempty        <= (w_gnext == s_wptr);
            r_rcount        <= w_cnext;
            r_ralmost_empty <= (w_cnext <= r_thresh);
            // A fresh underflow outranks a simultaneous clear.
            if (rd_en && r_rempty && !rflush) begin
                r_runderflow <= 1'b1;
            end else if (urun_clr) begin
                r_runderflow <= 1'b0;
            end
            if (ae_thresh_we) begin
                r_thresh <= ae_thresh_in;
            end
        end
    end

    assign raddr         = r_rbin[ASIZE-1:0];
    assign rptr          = r_rptr;
    assign rempty        = r_rempty;
    assign ralmost_empty = r_ralmost_empty;
    assign rcount        = r_rcount;
    assign runderflow    = r_runderflow;

endmodule
`default_nettype wire

// File: tb/tb_rptr_empty_lvl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rptr_empty_lvl
// Description : Scoreboard bench for rptr_empty_lvl against a counter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rptr_empty_lvl;

    localparam int DEPTH = 16;
    localparam int MOD   = 32;

    typedef struct {
        logic [4:0] rptr;
        logic [3:0] raddr;
        logic       empty;
        logic       ae;
        logic [4:0] cnt;
        logic       uf;
    } exp_t;

    logic       rd_clk = 1'b0;
    logic       rrst = 1'b1;
    logic       rd_en = 1'b0;
    logic       rflush = 1'b0;
    logic [4:0] s_wptr = '0;
    logic       ae_thresh_we = 1'b0;
    logic [4:0] ae_thresh_in = '0;
    logic       urun_clr = 1'b0;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rcount;
    logic       runderflow;

    always #5 rd_clk = ~rd_clk;

    rptr_empty_lvl #(
        .ASIZE    (4),
        .AE_RESET (2)
    ) dut (
        .rd_clk        (rd_clk),
        .rrst          (rrst),
        .rd_en         (rd_en),
        .rflush        (rflush),
        .s_wptr        (s_wptr),
        .ae_thresh_we  (ae_thresh_we),
        .ae_thresh_in  (ae_thresh_in),
        .urun_clr      (urun_clr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rcount        (rcount),
        .runderflow    (runderflow)
    );

    // Model: plain integer read/write counts modulo 32.
    int   m_rd = 0;
    int   m_wr = 0;
    int   m_cnt = 0;
    int   m_thr = 2;
    bit   m_empty = 1;
    bit   m_ae = 1;
    bit   m_uf = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    function automatic logic [4:0] to_gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit re, input bit fl, input bit we,
                        input int thr_in, input bit clr, input int winc);
        bit   pop;
        exp_t x;
        @(negedge rd_clk);
        if (rst) m_wr = 0;
        else if ((m_wr + winc - m_rd + MOD) % MOD <= DEPTH) m_wr = (m_wr + winc) % MOD;
        rrst         = rst;
        rd_en        = re;
        rflush       = fl;
        ae_thresh_we = we;
        ae_thresh_in = thr_in[4:0];
        urun_clr     = clr;
        s_wptr       = to_gray(m_wr);
        if (rst) begin
            m_rd = 0; m_cnt = 0; m_empty = 1; m_ae = 1; m_uf = 0; m_thr = 2;
        end else begin
            pop = re && !m_empty;
            if (re && m_empty && !fl) m_uf = 1;
            else if (clr) m_uf = 0;
            m_rd    = fl ? m_wr : (m_rd + int'(pop)) % MOD;
            m_cnt   = (m_wr - m_rd + MOD) % MOD;
            m_empty = (m_cnt == 0);
            m_ae    = (m_cnt <= m_thr);
            if (we) m_thr = thr_in;
        end
        x.rptr  = to_gray(m_rd);
        x.raddr = 4'(m_rd % DEPTH);
        x.empty = m_empty;
        x.ae    = m_ae;
        x.cnt   = 5'(m_cnt);
        x.uf    = m_uf;
        sb.push_back(x);
    endtask

    // Monitor: every edge presents a fresh registered status word.
    always @(posedge rd_clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rptr", int'(rptr), int'(e.rptr));
            chk("raddr", int'(raddr), int'(e.raddr));
            chk("rempty", int'(rempty), int'(e.empty));
            chk("ralmost_empty", int'(ralmost_empty), int'(e.ae));
            chk("rcount", int'(rcount), int'(e.cnt));
            chk("runderflow", int'(runderflow), int'(e.uf));
        end
    end

    initial begin
        // Reset with random side inputs
        repeat (2) step(1, 1'($urandom), 1'($urandom), 1'($urandom),
                        int'($urandom_range(0, 16)), 1'($urandom), 0);
        // Fill to 3, drain to empty
        step(0, 0, 0, 1, 2, 0, 3);
        step(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0, 0);
        // Underflow, clear collision, then clear
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        // Threshold reprogram with 6 entries, then flush with rd_en
        step(0, 0, 0, 0, 0, 0, 6);
        step(0, 0, 0, 1, 6, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 4);
        step(0, 0, 0, 0, 0, 0, 0);
        // Random traffic across many pointer wraps, with occasional reset
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 250) == 0,
                 1'($urandom),
                 ($urandom % 40) == 0,
                 ($urandom % 20) == 0,
                 int'($urandom_range(0, 16)),
                 ($urandom % 10) == 0,
                 (($urandom % 3) == 0) ? 0 : 1);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        @(posedge rd_clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
